// File: rtl/ste_xadc_drp_reader.sv
// XADC DRP status reader: on each end-of-conversion, issues one DRP read and
// presents the right-justified 12-bit result to the averaging filter.
module ste_xadc_drp_reader #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [6:0]        addr_i,
  input  logic              eoc_i,
  output logic              den_o,
  output logic              dwe_o,
  output logic [6:0]        daddr_o,
  input  logic              drdy_i,
  input  logic [15:0]       do_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic              avg_clr_o,
  output logic              timeout_o,
  output logic              overrun_o,
  output logic [1:0]        state_o
);

  // Handshake: den_o is a one-cycle request issued in REQ; drdy_i is a
  // one-cycle response honoured only in WAIT, anything else is spurious.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  logic       pending;
  logic       first_flag;
  logic [6:0] last_addr;
  logic [7:0] tcnt;

  assign dwe_o   = 1'b0;
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      first_flag   <= 1'b1;
      last_addr    <= 7'd0;
      tcnt         <= 8'd0;
      den_o        <= 1'b0;
      daddr_o      <= 7'd0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      avg_clr_o    <= 1'b0;
      timeout_o    <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      den_o        <= 1'b0;
      dout_valid_o <= 1'b0;
      avg_clr_o    <= 1'b0;

      case (state)
        IDLE: begin
          tcnt <= 8'd0;
          if (en_i && (eoc_i || pending)) begin
            state     <= REQ;
            daddr_o   <= addr_i;
            pending   <= 1'b0;
            den_o     <= 1'b1;
            // A new channel (or first sample after enable) restarts the averager.
            avg_clr_o <= first_flag || (addr_i != last_addr);
          end
        end

        REQ: begin
          last_addr  <= daddr_o;
          first_flag <= 1'b0;
          tcnt       <= 8'd0;
          state      <= WAIT;
          if (eoc_i) begin
            if (pending) overrun_o <= 1'b1;
            pending <= 1'b1;
          end
        end

        WAIT: begin
          if (drdy_i) begin
            dout_o       <= DATA_W'(do_i[15:4]);
            dout_valid_o <= en_i;
            tcnt         <= 8'd0;
            state        <= IDLE;
          end else if (tcnt == TMAX) begin
            timeout_o <= 1'b1;
            tcnt      <= 8'd0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
          if (eoc_i) begin
            if (pending) overrun_o <= 1'b1;
            pending <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Disable lets an in-flight read finish but drops all queued work and flags.
      if (!en_i) begin
        pending    <= 1'b0;
        timeout_o  <= 1'b0;
        overrun_o  <= 1'b0;
        first_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ste_xadc_drp_reader.sv
// Self-checking bench for ste_xadc_drp_reader: scenario tasks drive DRP traffic,
// a negedge monitor collects samples that are checked against an expected queue.
module tb_ste_xadc_drp_reader;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic [6:0]  addr_i;
  logic        eoc_i;
  logic        den_o;
  logic        dwe_o;
  logic [6:0]  daddr_o;
  logic        drdy_i;
  logic [15:0] do_i;
  logic [15:0] dout_o;
  logic        dout_valid_o;
  logic        avg_clr_o;
  logic        timeout_o;
  logic        overrun_o;
  logic [1:0]  state_o;

  int tests;
  int fails;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int den_cnt;
  int clr_bad;
  int den_long;
  logic den_prev;

  ste_xadc_drp_reader #(.DATA_W(16), .TIMEOUT_CYC(63)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .addr_i(addr_i), .eoc_i(eoc_i),
    .den_o(den_o), .dwe_o(dwe_o), .daddr_o(daddr_o), .drdy_i(drdy_i), .do_i(do_i),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o), .avg_clr_o(avg_clr_o),
    .timeout_o(timeout_o), .overrun_o(overrun_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: collect output samples and pulse statistics away from the active edge
  always @(negedge clk) begin
    if (dout_valid_o) got_q.push_back(dout_o);
    if (den_o) den_cnt = den_cnt + 1;
    if (avg_clr_o && !den_o) clr_bad = clr_bad + 1;
    if (den_o && den_prev) den_long = den_long + 1;
    den_prev = den_o;
  end

  // driver tasks
  task automatic pulse_eoc();
    @(posedge clk); #1 eoc_i = 1'b1;
    @(posedge clk); #1 eoc_i = 1'b0;
  endtask

  task automatic wait_den(output int lat);
    lat = 0;
    @(negedge clk);
    while (!den_o && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic respond(input logic [15:0] data, input int dly);
    repeat (dly) @(posedge clk);
    #1 drdy_i = 1'b1; do_i = data;
    @(posedge clk);
    #1 drdy_i = 1'b0; do_i = 16'h0;
  endtask

  task automatic run_txn(input logic [15:0] data, input int dly, input bit exp_v,
                         output int lat, output logic clr_seen, output logic [6:0] addr_seen);
    pulse_eoc();
    wait_den(lat);
    clr_seen  = avg_clr_o;
    addr_seen = daddr_o;
    if (exp_v) exp_q.push_back({4'h0, data[15:4]});
    respond(data, dly);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en_i = 1'b0; addr_i = 7'h0; eoc_i = 1'b0; drdy_i = 1'b0; do_i = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if ({den_o, dwe_o, daddr_o, dout_o, dout_valid_o, avg_clr_o, timeout_o, overrun_o} !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: den=%b dwe=%b daddr=%h dout=%h valid=%b clr=%b to=%b ov=%b, want all 0",
               den_o, dwe_o, daddr_o, dout_o, dout_valid_o, avg_clr_o, timeout_o, overrun_o);
    end
    tests++;
    if (state_o !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_o); end
  endtask

  task automatic test_basic();
    int lat; logic clr; logic [6:0] a; logic [15:0] e, g;
    en_i = 1'b1; addr_i = 7'h03;
    den_cnt = 0;
    run_txn(16'h7D00, 2, 1'b1, lat, clr, a);
    tests++; if (lat !== 0) begin fails++; $display("FAIL basic_den_latency: got %0d want 0", lat); end
    tests++; if (a !== 7'h03) begin fails++; $display("FAIL basic_daddr: got %h want 03", a); end
    tests++; if (clr !== 1'b1) begin fails++; $display("FAIL basic_avg_clr: got %b want 1", clr); end
    tests++; if (den_cnt !== 1) begin fails++; $display("FAIL basic_den_count: got %0d want 1", den_cnt); end
    tests++; if (dwe_o !== 1'b0) begin fails++; $display("FAIL basic_dwe: got %b want 0", dwe_o); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL basic_valid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL basic_dout: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_addr_change();
    int lat; logic clr; logic [6:0] a; logic [15:0] e, g;
    run_txn(16'hFFF0, 1, 1'b1, lat, clr, a);
    tests++; if (clr !== 1'b0) begin fails++; $display("FAIL same_addr_clr: got %b want 0", clr); end
    addr_i = 7'h10;
    run_txn(16'hFFF0, 1, 1'b1, lat, clr, a);
    tests++; if (clr !== 1'b1) begin fails++; $display("FAIL new_addr_clr: got %b want 1", clr); end
    tests++; if (a !== 7'h10) begin fails++; $display("FAIL new_addr_daddr: got %h want 10", a); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL addr_valid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL addr_dout: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_timeout();
    int lat, k; logic clr; logic [6:0] a; logic [15:0] e, g;
    pulse_eoc();
    wait_den(lat);
    k = 0;
    while (!timeout_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    tests++; if (k !== 64) begin fails++; $display("FAIL timeout_cycles: got %0d want 64", k); end
    repeat (3) @(negedge clk);
    tests++; if (timeout_o !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", timeout_o); end
    tests++; if (dout_o !== 16'h0FFF) begin fails++; $display("FAIL timeout_dout_hold: got %h want 0fff", dout_o); end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL timeout_no_valid: got %0d want 0", got_q.size()); end
    got_q.delete();
    run_txn(16'hABC0, 3, 1'b1, lat, clr, a);
    tests++; if (lat !== 0) begin fails++; $display("FAIL timeout_next_den: got %0d want 0", lat); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL timeout_next_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL timeout_next_dout: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overrun();
    int lat; logic [15:0] e, g;
    den_cnt = 0;
    tests++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL overrun_before: got %b want 0", overrun_o); end
    pulse_eoc();
    wait_den(lat);
    pulse_eoc();
    pulse_eoc();
    exp_q.push_back(16'h0111);
    respond(16'h1110, 1);
    wait_den(lat);
    tests++; if (lat >= 20) begin fails++; $display("FAIL overrun_extra_den: waited %0d cycles want <20", lat); end
    exp_q.push_back(16'h0222);
    respond(16'h2220, $urandom_range(1, 5));
    repeat (10) @(negedge clk);
    tests++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b want 1", overrun_o); end
    tests++; if (den_cnt !== 2) begin fails++; $display("FAIL overrun_den_count: got %0d want 2", den_cnt); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL overrun_valid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL overrun_dout: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] e, g;
    pulse_eoc();
    wait_den(lat);
    exp_q.push_back(16'h0777);
    @(posedge clk); #1 eoc_i = 1'b1; drdy_i = 1'b1; do_i = 16'h7770;
    @(posedge clk); #1 eoc_i = 1'b0; drdy_i = 1'b0; do_i = 16'h0;
    wait_den(lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL b2b_next_den_latency: got %0d want 1", lat); end
    exp_q.push_back(16'h0888);
    respond(16'h8880, 1);
    repeat (3) @(negedge clk);
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_valid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL b2b_dout: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_en_drop();
    int lat, d0; logic clr; logic [6:0] a; logic [15:0] e, g;
    pulse_eoc();
    wait_den(lat);
    @(posedge clk); #1 en_i = 1'b0;
    respond(16'h5550, 2);
    repeat (3) @(negedge clk);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL endrop_no_valid: got %0d want 0", got_q.size()); end
    tests++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL endrop_timeout_clr: got %b want 0", timeout_o); end
    tests++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL endrop_overrun_clr: got %b want 0", overrun_o); end
    got_q.delete();
    d0 = den_cnt;
    pulse_eoc();
    repeat (4) @(negedge clk);
    tests++; if (den_cnt !== d0) begin fails++; $display("FAIL endrop_no_start: got %0d den want %0d", den_cnt, d0); end
    en_i = 1'b1;
    run_txn(16'h6660, 1, 1'b1, lat, clr, a);
    tests++; if (clr !== 1'b1) begin fails++; $display("FAIL reenable_clr: got %b want 1", clr); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL reenable_valid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL reenable_dout: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_spurious_drdy();
    @(posedge clk); #1 drdy_i = 1'b1; do_i = 16'h1230;
    @(posedge clk); #1 drdy_i = 1'b0; do_i = 16'h0;
    repeat (3) @(negedge clk);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL spurious_valid: got %0d want 0", got_q.size()); end
    tests++; if (dout_o !== 16'h0666) begin fails++; $display("FAIL spurious_dout: got %h want 0666", dout_o); end
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    int lat, d0; logic clr; logic [6:0] a; logic [15:0] e, g;
    pulse_eoc();
    wait_den(lat);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({den_o, daddr_o, dout_o, dout_valid_o, avg_clr_o, timeout_o, overrun_o, state_o} !== 33'h0) begin
      fails++;
      $display("FAIL midreset_outputs: den=%b daddr=%h dout=%h valid=%b clr=%b to=%b ov=%b st=%0d, want all 0",
               den_o, daddr_o, dout_o, dout_valid_o, avg_clr_o, timeout_o, overrun_o, state_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = den_cnt;
    repeat (6) @(negedge clk);
    tests++; if (den_cnt !== d0) begin fails++; $display("FAIL midreset_no_reissue: got %0d den want %0d", den_cnt, d0); end
    run_txn(16'h9990, 1, 1'b1, lat, clr, a);
    tests++; if (clr !== 1'b1) begin fails++; $display("FAIL midreset_first_clr: got %b want 1", clr); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL midreset_valid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests++; if (g !== e) begin fails++; $display("FAIL midreset_dout: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_pulse_shape();
    tests++; if (clr_bad !== 0) begin fails++; $display("FAIL clr_without_den: got %0d want 0", clr_bad); end
    tests++; if (den_long !== 0) begin fails++; $display("FAIL den_multi_cycle: got %0d want 0", den_long); end
  endtask

  initial begin
    tests = 0; fails = 0; den_cnt = 0; clr_bad = 0; den_long = 0; den_prev = 1'b0;
    test_reset();
    test_basic();
    test_addr_change();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_en_drop();
    test_spurious_drdy();
    test_reset_mid();
    test_pulse_shape();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
